parity_share_ctrl: RTL and testbench
====================================

Name: parity_share_ctrl

Overview:
- Time-shares one bit-serial parity engine between two requesters: a generator port (computes the parity bit for a byte) and a checker port (validates a byte plus its received parity bit).
- Sits between the byte-level link logic and the parity datapath; replaces two parallel XOR trees with one sequenced engine.
- Includes a round-robin arbiter, a shift/accumulate FSM and one-cycle done pulses per port.

Parameters:
DATA_W, 8, payload width in bits; also the number of SHIFT cycles (legal range 2..32)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
gen_req  input  1  generator request, level
gen_data  input  DATA_W  byte to protect; sampled on gen_gnt cycle
gen_odd  input  1  0 = even parity, 1 = odd parity; sampled with gen_data
gen_gnt  output  1  one-cycle pulse: gen request accepted this cycle
gen_done  output  1  one-cycle pulse: gen_p valid
gen_p  output  1  generated parity bit, held until next gen_done
chk_req  input  1  checker request, level
chk_data  input  DATA_W  received byte; sampled on chk_gnt cycle
chk_p_in  input  1  received parity bit; sampled with chk_data
chk_odd  input  1  0 = even, 1 = odd; sampled with chk_data
chk_gnt  output  1  one-cycle pulse: chk request accepted
chk_done  output  1  one-cycle pulse: chk_ok valid
chk_ok  output  1  1 = parity correct, held until next chk_done
busy  output  1  1 while in SHIFT or DONE

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; all outputs 0; shift reg, bit counter and accumulator cleared; last_owner=CHK, so gen wins the first tie.
- FSM states:
  - IDLE: if any req, grant per arbiter, go to SHIFT.
  - SHIFT: lasts exactly DATA_W cycles, then go to DONE.
  - DONE: 1 cycle, then go to IDLE.
- Arbiter (evaluated only in IDLE):
  - Only one req high: that port wins.
  - Both high: the port not equal to last_owner wins; last_owner updates on every grant.
  - Requests arriving while busy wait. No queueing; req level is re-sampled in IDLE.
- Grant cycle (IDLE with req):
  - gnt pulse for the winner.
  - Load data into the shift reg. Load the accumulator with odd (gen) or odd^p_in (chk).
  - Latch owner; counter = 0.
- SHIFT: each cycle acc ^= shreg[0]; shreg >>= 1; counter++. Exit when counter == DATA_W-1.
- DONE:
  - Owner gen: gen_p <= acc, gen_done=1. Result is p = XOR(data)^odd, so {p,data} has the requested parity.
  - Owner chk: chk_ok <= ~acc, chk_done=1. ok=1 iff XOR(data,p_in) equals odd.
  - The non-owner's held result is unchanged.
- Latency: gnt in cycle T, done in cycle T+DATA_W+1, next grant earliest T+DATA_W+2. Throughput is one request per DATA_W+2 cycles.
- Requester rules:
  - data/odd/p_in need be valid only in the gnt cycle.
  - req still high in IDLE after own done counts as a new request.
  - Requester should drop req on the cycle after gnt. If req stays high through SHIFT, this is not an error.
- Reset mid-operation: abort immediately. No done pulse; results cleared to 0.
- busy=0 only in IDLE. gnt is never asserted while busy. gen_gnt and chk_gnt are never high together; same for the done pulses.

Decomposition:
- Shared package holds:
  - owner encoding (OWN_GEN=0, OWN_CHK=1)
  - state encoding (ST_IDLE, ST_SHIFT, ST_DONE)
  - PARITY_EVEN=0 / PARITY_ODD=1 constants
- One natural sub-module: parity_serial_core. It holds the shift reg, counter and XOR accumulator, with load/start in and acc/last out.
- The arbiter and FSM stay in the top.

Test Plan:
- Reset: rst_n=0 mid-SHIFT of a gen request with gen_data=8'hAB → all outputs 0 immediately; no gen_done after release; next request restarts cleanly.
- Gen even: gen_req=1, gen_data=8'b10101011, gen_odd=0 → gen_gnt at T, gen_done at T+9 with gen_p=1. Same data with gen_odd=1 → gen_p=0.
- Chk: chk_data=8'b10101010, chk_p_in=0, chk_odd=0 → chk_ok=1. Same with chk_p_in=1 → chk_ok=0. With chk_odd=1, chk_p_in=1 → chk_ok=1.
- Arbitration tie: both req high from reset → gen granted first, chk granted at T+10, gen again next if still requesting (strict alternation). busy stays high across each job, low for exactly one IDLE cycle between jobs.
- Result hold: gen job gives gen_p=1, then a chk job runs → gen_p stays 1 throughout; the done pulses never overlap.
- Random: 1000 random requests on both ports, scoreboard against reduction XOR → every done within DATA_W+1 cycles of its gnt, all results match.

Source files
------------

// File: rtl/parity_share_ctrl_pkg.sv
//==============================================================================
// Module      : parity_share_ctrl_pkg
// Description : Owner/state encodings and parity-sense constants shared by the
//               parity share controller and its serial core.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package parity_share_ctrl_pkg;

    typedef enum logic {
        OWN_GEN = 1'b0,
        OWN_CHK = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/parity_serial_core.sv
//==============================================================================
// Module      : parity_serial_core
// Description : Bit-serial XOR engine: shift register, bit counter and
//               accumulator; one payload bit is folded in per shift cycle.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module parity_serial_core #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              acc_init_i,
    input  logic              shift_i,
    output logic              acc_o,
    output logic              last_o
);
    import parity_share_ctrl_pkg::*;

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0] sh_q, sh_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              acc_q, acc_d;

    always_comb begin
        sh_d  = sh_q;
        cnt_d = cnt_q;
        acc_d = acc_q;
        if (load_i) begin
            sh_d  = data_i;
            cnt_d = '0;
            acc_d = acc_init_i;
        end else if (shift_i) begin
            acc_d = acc_q ^ sh_q[0];
            sh_d  = sh_q >> 1;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q  <= '0;
            cnt_q <= '0;
            acc_q <= PARITY_EVEN;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

    assign acc_o  = acc_q;
    assign last_o = (cnt_q == CNT_W'(DATA_W - 1));

endmodule

`default_nettype wire

// File: rtl/parity_share_ctrl.sv
//==============================================================================
// Module      : parity_share_ctrl
// Description : Round-robin time-sharing of one serial parity engine between a
//               parity generator port and a parity checker port.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module parity_share_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              gen_req,
    input  logic [DATA_W-1:0] gen_data,
    input  logic              gen_odd,
    output logic              gen_gnt,
    output logic              gen_done,
    output logic              gen_p,
    input  logic              chk_req,
    input  logic [DATA_W-1:0] chk_data,
    input  logic              chk_p_in,
    input  logic              chk_odd,
    output logic              chk_gnt,
    output logic              chk_done,
    output logic              chk_ok,
    output logic              busy
);
    import parity_share_ctrl_pkg::*;

    state_e state_q, state_d;
    owner_e owner_q, owner_d;
    logic   gen_p_q, gen_p_d;
    logic   chk_ok_q, chk_ok_d;

    logic              w_grant;
    logic              w_win_gen;
    logic              w_acc;
    logic              w_last;
    logic [DATA_W-1:0] w_load_data;
    logic              w_load_acc;

    // owner_q doubles as last_owner: it only changes on a grant.
    assign w_win_gen   = gen_req & (~chk_req | (owner_q == OWN_CHK));
    assign w_grant     = (state_q == ST_IDLE) & (gen_req | chk_req);
    assign w_load_data = w_win_gen ? gen_data : chk_data;
    assign w_load_acc  = w_win_gen ? gen_odd : (chk_odd ^ chk_p_in);

    parity_serial_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (w_grant),
        .data_i     (w_load_data),
        .acc_init_i (w_load_acc),
        .shift_i    (state_q == ST_SHIFT),
        .acc_o      (w_acc),
        .last_o     (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWN_CHK;
            gen_p_q  <= 1'b0;
            chk_ok_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            gen_p_q  <= gen_p_d;
            chk_ok_q <= chk_ok_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            ST_IDLE: begin
                if (w_grant) begin
                    state_d = ST_SHIFT;
                    owner_d = w_win_gen ? OWN_GEN : OWN_CHK;
                end
            end
            ST_SHIFT: if (w_last) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Results are presented straight from the accumulator during DONE and
    // held in the per-port registers afterwards.
    always_comb begin
        gen_gnt  = w_grant & w_win_gen;
        chk_gnt  = w_grant & ~w_win_gen;
        gen_done = (state_q == ST_DONE) & (owner_q == OWN_GEN);
        chk_done = (state_q == ST_DONE) & (owner_q == OWN_CHK);
        busy     = (state_q != ST_IDLE);
        gen_p_d  = gen_done ? w_acc : gen_p_q;
        chk_ok_d = chk_done ? ~w_acc : chk_ok_q;
        gen_p    = gen_p_d;
        chk_ok   = chk_ok_d;
    end

endmodule

`default_nettype wire

// File: tb/tb_parity_share_ctrl.sv
//==============================================================================
// Module      : tb_parity_share_ctrl
// Description : Directed and randomized self-checking bench for parity_share_ctrl.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_parity_share_ctrl;

    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              gen_req, gen_odd, chk_req, chk_p_in, chk_odd;
    logic [DATA_W-1:0] gen_data, chk_data;
    logic              gen_gnt, gen_done, gen_p, chk_gnt, chk_done, chk_ok, busy;

    int n_cmp = 0;
    int n_err = 0;
    logic m_gen_p  = 1'b0;
    logic m_chk_ok = 1'b0;

    always #5 clk = ~clk;

    parity_share_ctrl #(.DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .gen_req  (gen_req),
        .gen_data (gen_data),
        .gen_odd  (gen_odd),
        .gen_gnt  (gen_gnt),
        .gen_done (gen_done),
        .gen_p    (gen_p),
        .chk_req  (chk_req),
        .chk_data (chk_data),
        .chk_p_in (chk_p_in),
        .chk_odd  (chk_odd),
        .chk_gnt  (chk_gnt),
        .chk_done (chk_done),
        .chk_ok   (chk_ok),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] all_outs();
        return {gen_gnt, gen_done, gen_p, chk_gnt, chk_done, chk_ok, busy};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        gen_req = 1'b0;
        chk_req = 1'b0;
        #1;
        check("reset_outs", {25'd0, all_outs()}, 32'd0);
        m_gen_p  = 1'b0;
        m_chk_ok = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One job on one port, started from IDLE; checks grant, latency, result
    // and that the other port neither pulses done nor loses its held result.
    task automatic do_job(input bit is_chk, input logic [DATA_W-1:0] d,
                          input bit odd, input bit pin, input bit exp, input string tag);
        int lat;
        bit seen;
        @(negedge clk);
        if (is_chk) begin
            chk_req = 1'b1; chk_data = d; chk_odd = odd; chk_p_in = pin;
        end else begin
            gen_req = 1'b1; gen_data = d; gen_odd = odd;
        end
        #1;
        check({tag, "_gnt"}, {30'd0, gen_gnt, chk_gnt}, is_chk ? 32'd1 : 32'd2);
        lat  = 0;
        seen = 1'b0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(negedge clk);
            gen_req = 1'b0;
            chk_req = 1'b0;
            gen_data = DATA_W'($urandom);
            chk_data = DATA_W'($urandom);
            gen_odd  = 1'($urandom);
            chk_odd  = 1'($urandom);
            chk_p_in = 1'($urandom);
            #1;
            if (is_chk ? chk_done : gen_done) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        check({tag, "_lat"}, lat, DATA_W + 1);
        if (is_chk) begin
            check({tag, "_ok"}, chk_ok, exp);
            check({tag, "_other"}, {30'd0, gen_done, gen_p}, {30'd0, 1'b0, m_gen_p});
            m_chk_ok = exp;
        end else begin
            check({tag, "_p"}, gen_p, exp);
            check({tag, "_other"}, {30'd0, chk_done, chk_ok}, {30'd0, 1'b0, m_chk_ok});
            m_gen_p = exp;
        end
    endtask

    initial begin
        bit any_done;
        rst_n = 1'b0;
        gen_req = 1'b0; gen_data = '0; gen_odd = 1'b0;
        chk_req = 1'b0; chk_data = '0; chk_p_in = 1'b0; chk_odd = 1'b0;
        do_reset();

        // 8'b10101011 has five ones, 8'b10101010 has four
        do_job(1'b0, 8'b10101011, 1'b0, 1'b0, 1'b1, "gen_even");
        do_job(1'b0, 8'b10101011, 1'b1, 1'b0, 1'b0, "gen_odd");
        do_job(1'b1, 8'b10101010, 1'b0, 1'b0, 1'b1, "chk_even_p0");
        do_job(1'b1, 8'b10101010, 1'b0, 1'b1, 1'b0, "chk_even_p1");
        do_job(1'b1, 8'b10101010, 1'b1, 1'b1, 1'b1, "chk_odd_p1");
        do_job(1'b0, 8'b10101011, 1'b0, 1'b0, 1'b1, "hold_gen");
        do_job(1'b1, 8'b00000001, 1'b0, 1'b0, 1'b0, "hold_chk");
        check("hold_gen_p_after", gen_p, 1'b1);

        // Abort mid-shift: no done afterwards, results cleared
        @(negedge clk);
        gen_req = 1'b1; gen_data = 8'hAB; gen_odd = 1'b0;
        @(negedge clk);
        gen_req = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_outs", {25'd0, all_outs()}, 32'd0);
        m_gen_p  = 1'b0;
        m_chk_ok = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        any_done = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            #1;
            any_done |= gen_done | chk_done | busy;
        end
        check("abort_quiet", any_done, 1'b0);
        do_job(1'b0, 8'hAB, 1'b0, 1'b0, 1'b1, "restart");

        // Tie from reset: gen first, then strict alternation
        do_reset();
        @(negedge clk);
        gen_req = 1'b1; gen_data = 8'hAB; gen_odd = 1'b0;
        chk_req = 1'b1; chk_data = 8'hAA; chk_odd = 1'b0; chk_p_in = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            check($sformatf("tie_c%0d", c), {28'd0, gen_gnt, chk_gnt, busy, gen_done & chk_done},
                  {28'd0, (c == 0 || c == 20), (c == 10), (c % 10 != 0), 1'b0});
            if (c == 9)  check("tie_gen_p",  {30'd0, gen_done, gen_p},  32'd3);
            if (c == 19) check("tie_chk_ok", {30'd0, chk_done, chk_ok}, 32'd3);
        end
        gen_req = 1'b0;
        chk_req = 1'b0;
        repeat (12) @(negedge clk);
        m_gen_p  = gen_p;
        m_chk_ok = 1'b1;
        check("tie_end_chk_ok", chk_ok, 1'b1);
        check("tie_end_gen_p", gen_p, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            logic [DATA_W-1:0] d;
            bit is_chk, odd, pin, exp;
            d      = DATA_W'($urandom);
            is_chk = 1'($urandom);
            odd    = 1'($urandom);
            pin    = 1'($urandom);
            exp    = is_chk ? (((^d) ^ pin) == odd) : ((^d) ^ odd);
            do_job(is_chk, d, odd, pin, exp, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
